// File: rtl/char_buffer_writer.sv
// char_buffer_writer: terminal byte-stream interpreter driving the 64x16 character buffer write port
module char_buffer_writer #(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] buffer_waddr,
  output logic [7:0] buffer_din,
  output logic       buffer_wen,
  output logic [3:0] buffer_first_row,
  output logic       buffer_first_row_wen,
  output logic [3:0] cursor_row,
  output logic [5:0] cursor_col
);
  typedef enum logic [2:0] {IDLE, ESC, Y_ROW, Y_COL, CLEAR} state_t;
  state_t state;
  logic [3:0] first_row, clr_row, clr_end, nxt_row, cur_phys, nxt_phys;
  logic [5:0] clr_col, nxt_col, y_col;
  logic [7:0] y_off;
  logic [3:0] y_row;
  logic       accept, printable, clr_last;
  always_comb begin
    accept    = in_valid && in_ready;
    printable = in_data >= 8'h20 && in_data <= 8'h7e;
    y_off     = in_data - 8'h20;
    y_row     = in_data < 8'h20 ? 4'd0 : y_off > 8'd15 ? 4'd15 : y_off[3:0];
    y_col     = in_data < 8'h20 ? 6'd0 : y_off > 8'd63 ? 6'd63 : y_off[5:0];
    cur_phys  = cursor_row + first_row;
    clr_last  = clr_row == clr_end && clr_col == 6'd63;
    nxt_col   = clr_col + 6'd1;
    nxt_row   = clr_col == 6'd63 ? clr_row + 4'd1 : clr_row;
    nxt_phys  = nxt_row + first_row;
  end
  assign in_ready = state != CLEAR;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state                <= IDLE;
      first_row            <= '0;
      clr_row              <= '0;
      clr_col              <= '0;
      clr_end              <= '0;
      buffer_waddr         <= '0;
      buffer_din           <= '0;
      buffer_wen           <= 1'b0;
      buffer_first_row     <= '0;
      buffer_first_row_wen <= 1'b0;
      cursor_row           <= '0;
      cursor_col           <= '0;
    end else begin
      buffer_wen           <= 1'b0;
      buffer_first_row_wen <= 1'b0;
      if (state == CLEAR) begin
        if (clr_last) state <= IDLE;
        else begin
          clr_row      <= nxt_row;
          clr_col      <= nxt_col;
          buffer_wen   <= 1'b1;
          buffer_din   <= BLANK_CHAR;
          buffer_waddr <= {nxt_phys, nxt_col};
        end
      end else if (accept) begin
        case (state)
          IDLE: begin
            if (printable) begin
              buffer_wen   <= 1'b1;
              buffer_din   <= in_data;
              buffer_waddr <= {cur_phys, cursor_col};
              cursor_col   <= cursor_col == 6'd63 ? 6'd63 : cursor_col + 6'd1;
            end else if (in_data == 8'h0d) cursor_col <= '0;
            else if (in_data == 8'h08) cursor_col <= cursor_col == 6'd0 ? 6'd0 : cursor_col - 6'd1;
            else if (in_data == 8'h1b) state <= ESC;
            else if (in_data == 8'h0a) begin
              if (cursor_row != 4'd15) cursor_row <= cursor_row + 4'd1;
              else begin
                // new logical row 15 lands on the physical row that was the old top row
                first_row            <= first_row + 4'd1;
                buffer_first_row     <= first_row + 4'd1;
                buffer_first_row_wen <= 1'b1;
                clr_row              <= 4'd15;
                clr_col              <= '0;
                clr_end              <= 4'd15;
                buffer_wen           <= 1'b1;
                buffer_din           <= BLANK_CHAR;
                buffer_waddr         <= {first_row, 6'd0};
                state                <= CLEAR;
              end
            end
          end
          ESC: begin
            state <= IDLE;
            case (in_data)
              "A": cursor_row <= cursor_row == 4'd0 ? 4'd0 : cursor_row - 4'd1;
              "B": cursor_row <= cursor_row == 4'd15 ? 4'd15 : cursor_row + 4'd1;
              "C": cursor_col <= cursor_col == 6'd63 ? 6'd63 : cursor_col + 6'd1;
              "D": cursor_col <= cursor_col == 6'd0 ? 6'd0 : cursor_col - 6'd1;
              "H": begin
                cursor_row <= '0;
                cursor_col <= '0;
              end
              "J", "K": begin
                clr_row      <= cursor_row;
                clr_col      <= cursor_col;
                clr_end      <= in_data == "J" ? 4'd15 : cursor_row;
                buffer_wen   <= 1'b1;
                buffer_din   <= BLANK_CHAR;
                buffer_waddr <= {cur_phys, cursor_col};
                state        <= CLEAR;
              end
              "Y": state <= Y_ROW;
              default: ;
            endcase
          end
          Y_ROW: begin
            cursor_row <= y_row;
            state      <= Y_COL;
          end
          Y_COL: begin
            cursor_col <= y_col;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_char_buffer_writer.sv
// tb_char_buffer_writer: directed stimulus with a write/first-row scoreboard checked by a monitor
module tb_char_buffer_writer;
  logic       clk = 0, clr = 1, in_valid = 0, skip = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, buffer_wen, buffer_first_row_wen;
  logic [9:0] buffer_waddr;
  logic [7:0] buffer_din;
  logic [3:0] buffer_first_row, cursor_row;
  logic [5:0] cursor_col;
  int passed = 0, total = 0;
  logic [17:0] exp_w[$];
  logic [3:0]  exp_fr[$];

  char_buffer_writer dut (
    .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .buffer_waddr(buffer_waddr), .buffer_din(buffer_din), .buffer_wen(buffer_wen),
    .buffer_first_row(buffer_first_row), .buffer_first_row_wen(buffer_first_row_wen),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!clr && !skip) begin
      if (buffer_wen) begin
        if (exp_w.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write", buffer_waddr, buffer_din);
        end else begin
          logic [17:0] e;
          e = exp_w.pop_front();
          chk("write_addr", buffer_waddr, e[17:8]);
          chk("write_data", buffer_din, e[7:0]);
        end
      end
      if (buffer_first_row_wen) begin
        if (exp_fr.size() == 0) begin
          total++;
          $display("FAIL unexpected_first_row: got %0d expected no load", buffer_first_row);
        end else chk("first_row", buffer_first_row, exp_fr.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_valid = 1;
    while (!in_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) chk("send_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_ready(input string name, input int exp_n);
    int n = 0;
    while (!in_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, exp_n);
  endtask

  task automatic chk_cursor(input string name, input int r, input int c);
    chk({name, "_row"}, cursor_row, r);
    chk({name, "_col"}, cursor_col, c);
  endtask

  task automatic push_w(input int addr, input int data);
    exp_w.push_back({addr[9:0], data[7:0]});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wen", buffer_wen, 0);
    chk("rst_waddr", buffer_waddr, 0);
    chk("rst_din", buffer_din, 0);
    chk("rst_first_row", buffer_first_row, 0);
    chk("rst_first_row_wen", buffer_first_row_wen, 0);
    chk_cursor("rst", 0, 0);
    clr = 0;
    @(posedge clk); #1;

    push_w(0, 8'h48); push_w(1, 8'h69);
    send("H"); send("i");
    chk_cursor("hi", 0, 2);

    send(8'h1b); send("Y"); send(8'h25); send(8'h2a);
    chk_cursor("esc_y", 5, 10);
    push_w(330, 8'h58);
    send("X");
    chk_cursor("after_x", 5, 11);
    send(8'h7f);
    send(8'h1b); send("Y"); send(8'h7f); send(8'h7f);
    chk_cursor("esc_y_max", 15, 63);
    send(8'h0d);
    chk_cursor("cr", 15, 0);

    for (int k = 1; k <= 16; k++) begin
      exp_fr.push_back(4'(k));
      for (int c = 0; c < 64; c++) push_w((k - 1) * 64 + c, 8'h20);
      send(8'h0a);
      wait_ready("scroll_busy", 64);
      chk_cursor("scroll", 15, 0);
    end

    send(8'h1b); send("Y"); send(8'h23); send(8'h5c);
    for (int a = 252; a <= 255; a++) push_w(a, 8'h20);
    send(8'h1b); send("K");
    wait_ready("esc_k_busy", 4);
    chk_cursor("esc_k", 3, 60);

    send(8'h1b); send("Y"); send(8'h2e); send(8'h20);
    for (int a = 896; a <= 1023; a++) push_w(a, 8'h20);
    send(8'h1b); send("J");
    wait_ready("esc_j_busy", 128);
    chk_cursor("esc_j", 14, 0);

    send(8'h1b); send("H");
    send(8'h08);
    chk_cursor("bs_sat", 0, 0);
    send(8'h1b); send("A");
    chk_cursor("up_sat", 0, 0);
    send(8'h1b); send("D");
    chk_cursor("left_sat", 0, 0);
    for (int i = 0; i < 70; i++) begin
      push_w(i < 63 ? i : 63, "a" + i % 26);
      send(8'("a" + i % 26));
    end
    chk_cursor("col_sat", 0, 63);
    send(8'h1b); send("C");
    chk_cursor("right_sat", 0, 63);
    send(8'h1b); send("Y"); send(8'h05); send(8'h10);
    chk_cursor("y_low_clamp", 0, 0);
    send(8'h1b); send("Y"); send(8'h2f); send(8'h21);
    send(8'h1b); send("B");
    chk_cursor("down_sat", 15, 1);

    exp_fr.push_back(4'd1);
    for (int c = 0; c < 64; c++) push_w(c, 8'h20);
    send(8'h0a);
    wait_ready("scroll_again", 64);
    send(8'h1b); send("H");
    skip = 1;
    send(8'h1b); send("J");
    repeat (10) @(posedge clk);
    #2 clr = 1;
    #1;
    chk("abort_wen", buffer_wen, 0);
    chk("abort_in_ready", in_ready, 1);
    skip = 0;
    #10 clr = 0;
    @(posedge clk); #1;
    chk("post_abort_in_ready", in_ready, 1);
    chk_cursor("post_abort", 0, 0);
    push_w(0, 8'h5a);
    send("Z");
    chk_cursor("post_abort_z", 0, 1);

    repeat (5) @(posedge clk);
    #1;
    chk("writes_left", exp_w.size(), 0);
    chk("first_rows_left", exp_fr.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
